coor_gen_rr: RTL and testbench

- Parametrised successor to the pixel-coordinate generator.
- Scans an H_RES x V_RES frame with y fastest, then x, and converts each pixel to a signed Q8.24 complex-plane coordinate.
- Hands each coordinate to an idle Mandelbrot engine using round-robin arbitration, which replaces the old fixed lowest-index priority.
- Adds programmable origin and step for pan/zoom, start-triggered frames, and frame_start/frame_done pulses.

---
 rtl/coor_gen_rr_pkg.sv | 32 +++
 rtl/coor_gen_rr_rr_arbiter.sv | 42 ++++
 rtl/coor_gen_rr.sv | 136 +++++++++++++
 tb/tb_coor_gen_rr.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coor_gen_rr_pkg.sv
// Shared definitions for the round-robin coordinate generator.
// Holds the Q8.24 fixed-point constants, the layout of the engine work word,
// the FSM state encoding and the default frame geometry.
package coor_gen_rr_pkg;

    // Q8.24 signed fixed point: 8 integer bits, 24 fraction bits.
    localparam int FRAC_BITS = 24;
    localparam int COORD_W   = 32;

    // Work word layout, LSB first: {x, y, cx, cy}.
    localparam int CY_LSB = 0;
    localparam int CX_LSB = COORD_W;
    localparam int Y_LSB  = 2 * COORD_W;

    // x sits directly above y, so its offset depends on the y counter width.
    function automatic int x_lsb(input int y_w);
        return Y_LSB + y_w;
    endfunction

    // Default frame: 640x480 with a pitch of 0.0046875 (3.0 / 640).
    localparam int          DEF_H_RES = 640;
    localparam int          DEF_V_RES = 480;
    localparam int          DEF_X_W   = 10;
    localparam int          DEF_Y_W   = 9;
    localparam logic [31:0] DEF_STEP  = 32'h0001_3333;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/coor_gen_rr_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester found scanning upward from ptr, wrapping
// modulo NUM_PROC.
//   req       in  NUM_PROC  request vector (engine idle flags)
//   ptr       in  ADDR_W    highest-priority index for this cycle (< NUM_PROC)
//   gnt_valid out 1         at least one request present
//   gnt_idx   out ADDR_W    granted index (0 when gnt_valid is low)
module coor_gen_rr_rr_arbiter #(
    parameter int NUM_PROC = 4,
    parameter int ADDR_W   = 2
) (
    input  logic [NUM_PROC-1:0] req,
    input  logic [ADDR_W-1:0]   ptr,
    output logic                gnt_valid,
    output logic [ADDR_W-1:0]   gnt_idx
);

    int          sum;
    logic [ADDR_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = 0;
        idx       = '0;
        // Scan from farthest to nearest so the nearest requester wins last.
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_PROC) begin
                sum = sum - NUM_PROC;
            end
            idx = ADDR_W'(sum);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/coor_gen_rr.sv
// Pixel-coordinate generator with round-robin dispatch to Mandelbrot engines.
// Scans an H_RES x V_RES frame (y fastest) and accumulates Q8.24 plane
// coordinates cx = x0 + x*step, cy = y0 - y*step without multipliers.
//   cclk          in  1             clock
//   creset        in  1             asynchronous active-high reset
//   start         in  1             begin a frame when idle
//   cfg_x0        in  32            real coordinate of pixel x=0
//   cfg_y0        in  32            imaginary coordinate of row y=0
//   cfg_step      in  32            pixel pitch (unsigned magnitude)
//   cdones        in  NUM_PROC      per-engine idle flags
//   clatch_en     out 1             dispatch strobe
//   cengine_addr  out ADDR_W        engine receiving the dispatch
//   cword2engines out X_W+Y_W+64    {x, y, cx, cy}
//   busy          out 1             frame in progress
//   frame_start   out 1             pulse in the first cycle of a frame
//   frame_done    out 1             pulse after the last dispatch
module coor_gen_rr
    import coor_gen_rr_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int ADDR_W   = 2,
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W
) (
    input  logic                       cclk,
    input  logic                       creset,
    input  logic                       start,
    input  logic [COORD_W-1:0]         cfg_x0,
    input  logic [COORD_W-1:0]         cfg_y0,
    input  logic [COORD_W-1:0]         cfg_step,
    input  logic [NUM_PROC-1:0]        cdones,
    output logic                       clatch_en,
    output logic [ADDR_W-1:0]          cengine_addr,
    output logic [X_W+Y_W+2*COORD_W-1:0] cword2engines,
    output logic                       busy,
    output logic                       frame_start,
    output logic                       frame_done
);

    state_t              state;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COORD_W-1:0]  cx, cy;
    logic [COORD_W-1:0]  x0_q, y0_q, step_q;
    logic [ADDR_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]   last_addr;

    logic                gnt_valid;
    logic [ADDR_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0]   rr_next;
    logic                last_row;
    logic                last_pixel;

    coor_gen_rr_rr_arbiter #(
        .NUM_PROC (NUM_PROC),
        .ADDR_W   (ADDR_W)
    ) u_arb (
        .req       (cdones),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign clatch_en     = (state == S_RUN) && gnt_valid;
    // Between grants the address holds the last engine served.
    assign cengine_addr  = clatch_en ? gnt_idx : last_addr;
    assign cword2engines = {x, y, cx, cy};

    assign rr_next    = (gnt_idx == ADDR_W'(NUM_PROC - 1)) ? '0 : gnt_idx + ADDR_W'(1);
    assign last_row   = (y == Y_W'(V_RES - 1));
    assign last_pixel = last_row && (x == X_W'(H_RES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge cclk or posedge creset) begin
        if (creset) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            cx          <= '0;
            cy          <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            step_q      <= '0;
            rr_ptr      <= '0;
            last_addr   <= '0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x0_q        <= cfg_x0;
                        y0_q        <= cfg_y0;
                        step_q      <= cfg_step;
                        x           <= '0;
                        y           <= '0;
                        cx          <= cfg_x0;
                        cy          <= cfg_y0;
                        busy        <= 1'b1;
                        frame_start <= 1'b1;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    // start is deliberately not looked at here.
                    if (clatch_en) begin
                        rr_ptr    <= rr_next;
                        last_addr <= gnt_idx;
                        if (!last_row) begin
                            y  <= y + Y_W'(1);
                            cy <= cy - step_q;
                        end else begin
                            y  <= '0;
                            cy <= y0_q;
                            x  <= x + X_W'(1);
                            cx <= cx + step_q;
                        end
                        if (last_pixel) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coor_gen_rr.sv
// Directed self-checking bench for coor_gen_rr on a 4x3 frame, 4 engines.
module tb_coor_gen_rr;
    import coor_gen_rr_pkg::*;

    localparam int NP = 4;
    localparam int AW = 2;
    localparam int HR = 4;
    localparam int VR = 3;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int WW = XW + YW + 64;

    logic          cclk;
    logic          creset;
    logic          start;
    logic [31:0]   cfg_x0, cfg_y0, cfg_step;
    logic [NP-1:0] cdones;
    logic          clatch_en;
    logic [AW-1:0] cengine_addr;
    logic [WW-1:0] cword2engines;
    logic          busy;
    logic          frame_start;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;

    coor_gen_rr #(
        .NUM_PROC (NP),
        .ADDR_W   (AW),
        .H_RES    (HR),
        .V_RES    (VR),
        .X_W      (XW),
        .Y_W      (YW)
    ) dut (
        .cclk          (cclk),
        .creset        (creset),
        .start         (start),
        .cfg_x0        (cfg_x0),
        .cfg_y0        (cfg_y0),
        .cfg_step      (cfg_step),
        .cdones        (cdones),
        .clatch_en     (clatch_en),
        .cengine_addr  (cengine_addr),
        .cword2engines (cword2engines),
        .busy          (busy),
        .frame_start   (frame_start),
        .frame_done    (frame_done)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_addr(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected work word for scan index k (x = k / VR, y = k % VR).
    function automatic logic [WW-1:0] pix(input int k, input logic [31:0] x0,
                                          input logic [31:0] y0, input logic [31:0] st);
        logic [XW-1:0] xv;
        logic [YW-1:0] yv;
        logic [31:0]   cxv, cyv;
        xv  = XW'(k / VR);
        yv  = YW'(k % VR);
        cxv = x0 + 32'(k / VR) * st;
        cyv = y0 - 32'(k % VR) * st;
        return {xv, yv, cxv, cyv};
    endfunction

    task automatic check_all_zero(input string tag);
        check_bit ({tag, ".clatch_en"},   clatch_en,     1'b0);
        check_addr({tag, ".addr"},        cengine_addr,  '0);
        check_word({tag, ".word"},        cword2engines, '0);
        check_bit ({tag, ".busy"},        busy,          1'b0);
        check_bit ({tag, ".frame_start"}, frame_start,   1'b0);
        check_bit ({tag, ".frame_done"},  frame_done,    1'b0);
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    initial begin
        creset   = 1'b1;
        start    = 1'b0;
        cfg_x0   = '0;
        cfg_y0   = '0;
        cfg_step = '0;
        cdones   = 4'b1111;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        creset = 1'b0;
        tick();
        check_bit("idle_ignores_cdones", clatch_en, 1'b0);
        check_bit("idle_busy",           busy,      1'b0);

        // Frame 1: all engines idle, full scan.
        cfg_x0   = 32'hFE00_0000;
        cfg_y0   = 32'h0120_0000;
        cfg_step = 32'h0010_0000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < HR * VR; k++) begin
            check_bit ($sformatf("f1.latch%0d", k), clatch_en, 1'b1);
            check_addr($sformatf("f1.addr%0d", k), cengine_addr, AW'(k % NP));
            check_word($sformatf("f1.word%0d", k), cword2engines,
                       pix(k, 32'hFE00_0000, 32'h0120_0000, 32'h0010_0000));
            check_bit ($sformatf("f1.fstart%0d", k), frame_start, k == 0);
            check_bit ($sformatf("f1.busy%0d", k), busy, 1'b1);
            check_bit ($sformatf("f1.fdone%0d", k), frame_done, 1'b0);
            if (k == 5) begin
                check_word("f1.pixel_1_2", cword2engines,
                           {2'd1, 2'd2, 32'hFE10_0000, 32'h0100_0000});
            end
            tick();
        end
        check_bit("f1.end_busy",  busy,       1'b0);
        check_bit("f1.end_done",  frame_done, 1'b1);
        check_bit("f1.end_latch", clatch_en,  1'b0);
        tick();
        check_bit("f1.done_once", frame_done, 1'b0);

        // Frame 2: stall, then a restricted engine set, then abort.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_addr($sformatf("f2.addr%0d", k), cengine_addr, AW'(k));
            check_word($sformatf("f2.word%0d", k), cword2engines,
                       pix(k, 32'hFE00_0000, 32'h0120_0000, 32'h0010_0000));
            tick();
        end
        cdones = 4'b0000;
        #1;
        for (int c = 0; c < 5; c++) begin
            check_bit ($sformatf("stall.latch%0d", c), clatch_en, 1'b0);
            check_addr($sformatf("stall.addr%0d", c), cengine_addr, 2'd3);
            check_word($sformatf("stall.word%0d", c), cword2engines,
                       pix(4, 32'hFE00_0000, 32'h0120_0000, 32'h0010_0000));
            tick();
        end

        // Engines 1 and 3 only; start and a new step arrive mid-frame.
        cdones   = 4'b1010;
        start    = 1'b1;
        cfg_step = 32'h0020_0000;
        #1;
        for (int j = 0; j < 3; j++) begin
            check_bit ($sformatf("rr.latch%0d", j), clatch_en, 1'b1);
            check_addr($sformatf("rr.addr%0d", j), cengine_addr, (j % 2 == 0) ? 2'd1 : 2'd3);
            check_word($sformatf("rr.word%0d", j), cword2engines,
                       pix(4 + j, 32'hFE00_0000, 32'h0120_0000, 32'h0010_0000));
            tick();
            start = 1'b0;
            check_bit($sformatf("rr.no_fstart%0d", j), frame_start, 1'b0);
            check_bit($sformatf("rr.busy%0d", j), busy, 1'b1);
        end
        check_addr("rr.addr3", cengine_addr, 2'd3);
        check_word("rr.at_2_1", cword2engines,
                   {2'd2, 2'd1, 32'hFE20_0000, 32'h0110_0000});

        // Asynchronous abort at (2,1), mid-cycle.
        creset = 1'b1;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        creset   = 1'b0;
        cfg_step = 32'h0010_0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bit($sformatf("abort.no_fdone%0d", c), frame_done, 1'b0);
            check_bit($sformatf("abort.idle%0d", c),     busy,       1'b0);
        end

        // Frame 3: cx crosses the positive limit and wraps.
        cfg_x0 = 32'h7FF0_0000;
        cfg_y0 = 32'h0000_0000;
        cdones = 4'b1111;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check_bit("f3.fstart", frame_start, 1'b1);
        for (int k = 0; k < HR * VR; k++) begin
            check_addr($sformatf("f3.addr%0d", k), cengine_addr, AW'(k % NP));
            check_word($sformatf("f3.word%0d", k), cword2engines,
                       pix(k, 32'h7FF0_0000, 32'h0000_0000, 32'h0010_0000));
            if (k == 1) begin
                check_word("f3.cy_negative", cword2engines,
                           {2'd0, 2'd1, 32'h7FF0_0000, 32'hFFF0_0000});
            end
            if (k == 3) begin
                check_word("f3.cx_wrap", cword2engines,
                           {2'd1, 2'd0, 32'h8000_0000, 32'h0000_0000});
            end
            if (k == HR * VR - 1) begin
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check_bit("f3.end_busy", busy,       1'b0);
        check_bit("f3.end_done", frame_done, 1'b1);
        tick();
        check_bit("f3.start_ignored_busy",   busy,        1'b0);
        check_bit("f3.start_ignored_fstart", frame_start, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
